// File: rtl/q_action_ram.sv
`default_nettype none
// ============================================================================
// Module   : q_action_ram
// Purpose  : Single-clock table of signed action values with three access
//            paths: a registered read, a plain write, and a two-stage
//            saturating accumulate-update (read-modify-write). After reset the
//            table is swept to INIT_VAL, one entry per cycle, while busy is
//            high; every request is ignored during the sweep.
// Ports    : clk        - clock, all state on the rising edge
//            rst        - asynchronous active-high reset
//            en         - read enable
//            rd_addr    - read address
//            data_out   - registered read data (0 when no read)
//            rd_valid   - data_out holds a valid read
//            write_en   - plain write strobe
//            wr_addr    - plain write address
//            data_in    - plain write data
//            upd_en     - accumulate-update strobe
//            upd_addr   - update address
//            upd_delta  - signed increment
//            busy       - init sweep in progress
//            upd_sat    - one-cycle pulse: the committed update was clamped
// Revision : 1.0 - initial release
// ============================================================================
module q_action_ram #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_delta,
    output logic              busy,
    output logic              upd_sat
);

    localparam int                c_DEPTH     = 1 << ADDR_W;
    localparam logic [0:0]        c_ST_INIT   = 1'b0;
    localparam logic [0:0]        c_ST_RUN    = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;
    localparam logic [DATA_W-1:0] c_MAX       = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_MIN       = {1'b1, {(DATA_W-1){1'b0}}};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              w_busy;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    // Update pipeline register (stage 1 -> stage 2)
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_s1_delta;
    logic [DATA_W-1:0] r_s1_oper;

    logic [DATA_W:0]   w_sum;
    logic              w_ovf;
    logic [DATA_W-1:0] w_res;
    logic              w_rd;
    logic              w_wr;
    logic              w_upd;
    logic              w_commit;
    logic [DATA_W-1:0] w_oper;

    // ------------------------------------------------------------------------
    // FSM: state register (sweep counter lives alongside it)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_busy) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // FSM: next state -- leave INIT on the edge that writes the last entry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT: if (r_cnt == c_LAST_ADDR) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  w_state_nxt = c_ST_RUN;
            default:   w_state_nxt = c_ST_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy = (r_state == c_ST_INIT);
    end

    assign busy = w_busy;

    // ------------------------------------------------------------------------
    // Request qualification: nothing is accepted during the sweep
    // ------------------------------------------------------------------------
    assign w_rd  = ~w_busy & en;
    assign w_wr  = ~w_busy & write_en;
    assign w_upd = ~w_busy & upd_en;

    // ------------------------------------------------------------------------
    // Stage 2: saturating add with one guard bit; overflow shows up as the
    // guard bit disagreeing with the result sign bit.
    // ------------------------------------------------------------------------
    assign w_sum = {r_s1_oper[DATA_W-1], r_s1_oper} + {r_s1_delta[DATA_W-1], r_s1_delta};
    assign w_ovf = w_sum[DATA_W] ^ w_sum[DATA_W-1];
    assign w_res = w_ovf ? (w_sum[DATA_W] ? c_MIN : c_MAX) : w_sum[DATA_W-1:0];

    // A plain write to the same address on the same edge overrides the commit
    assign w_commit = r_s1_valid & ~(w_wr & (wr_addr == r_s1_addr));

    // Stage-1 operand: take whatever the entry will hold after this edge, so
    // back-to-back updates and write-then-update chains see fresh data.
    always_comb begin
        w_oper = r_mem[upd_addr];
        if (w_wr && (wr_addr == upd_addr)) begin
            w_oper = data_in;
        end else if (r_s1_valid && (r_s1_addr == upd_addr)) begin
            w_oper = w_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_delta <= '0;
            r_s1_oper  <= '0;
        end else begin
            r_s1_valid <= w_upd;
            if (w_upd) begin
                r_s1_addr  <= upd_addr;
                r_s1_delta <= upd_delta;
                r_s1_oper  <= w_oper;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs; reads return pre-edge contents (no forwarding)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            upd_sat  <= 1'b0;
        end else begin
            data_out <= w_rd ? r_mem[rd_addr] : '0;
            rd_valid <= w_rd;
            upd_sat  <= r_s1_valid & w_ovf;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: sweep write during INIT, otherwise commit then plain write
    // (the later assignment gives the plain write precedence)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else begin
            if (w_commit) begin
                r_mem[r_s1_addr] <= w_res;
            end
            if (w_wr) begin
                r_mem[wr_addr] <= data_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_q_action_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_q_action_ram
// Purpose  : Self-checking bench for q_action_ram (DATA_W=16, ADDR_W=6,
//            INIT_VAL=0). A behavioural table model predicts every registered
//            output; directed sequences add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_q_action_ram;

    localparam int c_DW    = 16;
    localparam int c_AW    = 6;
    localparam int c_DEPTH = 64;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              en        = 1'b0;
    logic [c_AW-1:0]   rd_addr   = '0;
    logic              write_en  = 1'b0;
    logic [c_AW-1:0]   wr_addr   = '0;
    logic [c_DW-1:0]   data_in   = '0;
    logic              upd_en    = 1'b0;
    logic [c_AW-1:0]   upd_addr  = '0;
    logic [c_DW-1:0]   upd_delta = '0;
    logic [c_DW-1:0]   data_out;
    logic              rd_valid;
    logic              busy;
    logic              upd_sat;

    q_action_ram #(
        .DATA_W   (c_DW),
        .ADDR_W   (c_AW),
        .INIT_VAL (16'h0000)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rd_addr   (rd_addr),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .write_en  (write_en),
        .wr_addr   (wr_addr),
        .data_in   (data_in),
        .upd_en    (upd_en),
        .upd_addr  (upd_addr),
        .upd_delta (upd_delta),
        .busy      (busy),
        .upd_sat   (upd_sat)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model state: table as plain integers, sweep cycles left, pending update
    int              m_mem [c_DEPTH];
    int              m_left;
    bit              m_pv;
    int              m_paddr;
    int              m_pop;
    int              m_pdelta;
    logic [c_DW-1:0] e_data;
    logic            e_valid;
    logic            e_sat;
    logic            e_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int clamp16(input int s);
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic model_reset();
        m_left  = c_DEPTH;
        m_pv    = 1'b0;
        e_data  = '0;
        e_valid = 1'b0;
        e_sat   = 1'b0;
        e_busy  = 1'b1;
    endtask

    // One rising edge of the table, using the inputs present at that edge
    task automatic model_edge();
        int old_rd;
        int s;
        int r;
        if (rst) begin
            model_reset();
        end else if (m_left > 0) begin
            m_mem[c_DEPTH - m_left] = 0;
            m_left--;
            e_data  = '0;
            e_valid = 1'b0;
            e_sat   = 1'b0;
            e_busy  = (m_left > 0);
        end else begin
            old_rd = m_mem[rd_addr];
            e_sat  = 1'b0;
            if (m_pv) begin
                s     = m_pop + m_pdelta;
                r     = clamp16(s);
                e_sat = (r != s);
                if (!(write_en && wr_addr == c_AW'(m_paddr))) m_mem[m_paddr] = r;
            end
            if (write_en) m_mem[wr_addr] = int'($signed(data_in));
            e_data  = en ? old_rd[c_DW-1:0] : '0;
            e_valid = en;
            e_busy  = 1'b0;
            // operand = what the entry holds once this edge has settled
            m_pv = upd_en;
            if (upd_en) begin
                m_paddr  = int'(upd_addr);
                m_pdelta = int'($signed(upd_delta));
                m_pop    = m_mem[upd_addr];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        en       = 1'b0;
        write_en = 1'b0;
        upd_en   = 1'b0;
    endtask

    task automatic sweep(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(name, n, 64);
    endtask

    task automatic rd(input int a);
        idle();
        en      = 1'b1;
        rd_addr = c_AW'(a);
        step();
        en = 1'b0;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     busy,     e_busy);
            check("rd_valid", rd_valid, e_valid);
            check("data_out", data_out, e_data);
            check("upd_sat",  upd_sat,  e_sat);
        end
    end

    initial begin
        #2 rst = 1'b1;
        model_reset();
        chk_en = 1'b1;
        #1 check("reset busy", busy, 1);
        check("reset data_out", data_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sweep("sweep length");

        // every entry initialised
        for (int i = 0; i < c_DEPTH; i++) begin
            rd(i);
            check("init value", data_out, 16'h0000);
            check("init rd_valid", rd_valid, 1);
        end

        // plain write, read back, then no read
        idle(); write_en = 1'b1; wr_addr = 6'd5; data_in = 16'h1234; step();
        rd(5);
        check("rd addr5", data_out, 16'h1234);
        idle(); step();
        check("no-read data", data_out, 16'h0000);
        check("no-read valid", rd_valid, 0);

        // three chained updates, read-old on the way
        idle(); upd_en = 1'b1; upd_addr = 6'd9; upd_delta = 16'd3; step();
        step();
        en = 1'b1; rd_addr = 6'd9; step();
        check("rd9 pre-edge a", data_out, 16'd3);
        upd_en = 1'b0; step();
        check("rd9 pre-edge b", data_out, 16'd6);
        step();
        check("rd9 final", data_out, 16'd9);
        check("no sat acc", upd_sat, 0);

        // positive saturation
        idle(); write_en = 1'b1; wr_addr = 6'd2; data_in = 16'h7FF0; step();
        idle(); upd_en = 1'b1; upd_addr = 6'd2; upd_delta = 16'h0020; step();
        idle(); step();
        check("sat pulse +", upd_sat, 1);
        rd(2);
        check("clamp max", data_out, 16'h7FFF);
        check("sat one cycle", upd_sat, 0);

        // negative saturation
        idle(); write_en = 1'b1; wr_addr = 6'd2; data_in = 16'h8005; step();
        idle(); upd_en = 1'b1; upd_addr = 6'd2; upd_delta = 16'hFFF0; step();
        idle(); step();
        check("sat pulse -", upd_sat, 1);
        rd(2);
        check("clamp min", data_out, 16'h8000);

        // write forwarded into a same-edge update
        idle(); write_en = 1'b1; wr_addr = 6'd7; data_in = 16'h0100;
        upd_en = 1'b1; upd_addr = 6'd7; upd_delta = 16'd1; step();
        idle(); step();
        rd(7);
        check("fwd write", data_out, 16'h0101);

        // plain write beats a colliding commit
        idle(); upd_en = 1'b1; upd_addr = 6'd7; upd_delta = 16'd1; step();
        idle(); write_en = 1'b1; wr_addr = 6'd7; data_in = 16'h0050; step();
        rd(7);
        check("write wins", data_out, 16'h0050);

        // distinct-address write, commit and read on one edge; negative delta
        idle(); write_en = 1'b1; wr_addr = 6'd10; data_in = 16'hAAAA;
        upd_en = 1'b1; upd_addr = 6'd11; upd_delta = 16'd5; step();
        idle(); write_en = 1'b1; wr_addr = 6'd12; data_in = 16'h5555;
        en = 1'b1; rd_addr = 6'd10; upd_en = 1'b1; upd_addr = 6'd13; upd_delta = 16'hFFFE; step();
        check("rd10", data_out, 16'hAAAA);
        idle(); step();
        rd(11); check("rd11", data_out, 16'd5);
        rd(12); check("rd12", data_out, 16'h5555);
        rd(13); check("rd13", data_out, 16'hFFFE);

        // reset ten cycles into a sweep
        idle();
        #2 rst = 1'b1; model_reset();
        @(negedge clk); rst = 1'b0;
        repeat (10) step();
        #2 rst = 1'b1; model_reset();
        #1 check("mid-sweep rst busy", busy, 1);
        @(negedge clk); rst = 1'b0;
        sweep("sweep after mid rst");

        // reset with an update sitting in stage 1
        idle(); write_en = 1'b1; wr_addr = 6'd20; data_in = 16'h0777; step();
        idle(); upd_en = 1'b1; upd_addr = 6'd20; upd_delta = 16'h7FFF;
        en = 1'b1; rd_addr = 6'd20; step();
        check("pre-rst rd20", data_out, 16'h0777);
        idle();
        #2 rst = 1'b1; model_reset();
        #1 check("async data_out", data_out, 0);
        check("async rd_valid", rd_valid, 0);
        check("async busy", busy, 1);
        @(negedge clk); rst = 1'b0;
        sweep("sweep after upd rst");
        check("no stale sat", upd_sat, 0);
        rd(20);
        check("pending dropped", data_out, 16'h0000);
        idle(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/q_action_ram.md
Q_ACTION_RAM -- requirements
Module: q_action_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width; stored values are signed two's complement.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; depth DEPTH = 2^ADDR_W.
REQ-003 SHALL have parameter INIT_VAL, default 0, DATA_W value written to every entry by the init sweep.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  in  1  read enable.
REQ-007 SHALL have port rd_addr  in  ADDR_W  read address.
REQ-008 SHALL have port data_out  out  DATA_W  registered read data.
REQ-009 SHALL have port rd_valid  out  1  data_out holds a valid read.
REQ-010 SHALL have port write_en  in  1  plain write strobe.
REQ-011 SHALL have port wr_addr  in  ADDR_W  write address.
REQ-012 SHALL have port data_in  in  DATA_W  write data.
REQ-013 SHALL have port upd_en  in  1  accumulate-update strobe.
REQ-014 SHALL have port upd_addr  in  ADDR_W  update address.
REQ-015 SHALL have port upd_delta  in  DATA_W  signed increment.
REQ-016 SHALL have port busy  out  1  init sweep in progress; all requests ignored.
REQ-017 SHALL have port upd_sat  out  1  one-cycle pulse, committed update clamped.

Function
REQ-018 SHALL implement FSM states INIT and RUN; rst forces INIT with sweep counter 0.
REQ-019 In INIT, SHALL write INIT_VAL to mem[cnt] each cycle, increment cnt, and enter RUN on the edge writing entry DEPTH-1 (exactly DEPTH cycles); busy=1 throughout INIT, 0 in RUN.
REQ-020 While busy, SHALL ignore en, write_en and upd_en entirely: no memory change, rd_valid=0.
REQ-021 Read: en=1 at edge N SHALL give data_out=mem[rd_addr] (contents before edge N) and rd_valid=1 after edge N; en=0 at edge N SHALL give data_out=0 and rd_valid=0.
REQ-022 Plain write: write_en=1 at edge N SHALL store data_in to mem[wr_addr] at edge N.
REQ-023 Update stage 1: upd_en=1 at edge N SHALL capture addr, delta and operand into a pipeline register.
REQ-024 Update stage 2: at edge N+1 SHALL write sat(operand+delta) to mem[addr]; throughput one update per cycle.
REQ-025 Sum SHALL be computed at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; upd_sat=1 for the cycle after the clamped commit edge, else 0.
REQ-026 Stage-1 operand priority at edge N: data_in if write_en and wr_addr==upd_addr; else stage-2 result if committing to upd_addr; else mem[upd_addr].
REQ-027 Plain write and stage-2 commit to the same address on the same edge: plain write SHALL win; commit discarded; upd_sat still reflects the computed clamp.
REQ-028 Reads SHALL not see same-edge writes or commits (read-old); no forwarding onto data_out.
REQ-029 Distinct-address write, commit and read on one edge SHALL all take effect.

Reset
REQ-030 On rst assertion, asynchronously: data_out=0, rd_valid=0, upd_sat=0, busy=1, update pipeline invalidated, cnt=0, state=INIT.
REQ-031 rst mid-sweep or mid-update SHALL discard the pending commit and restart the full DEPTH-cycle sweep after deassertion.
REQ-032 Memory contents before sweep completion SHALL be treated as undefined by users.

Verification (DATA_W=16, ADDR_W=6, INIT_VAL=0)
REQ-033 Release rst -> busy=1 for exactly 64 cycles; then read all 64 addresses -> each 0x0000, rd_valid=1 one cycle after en.
REQ-034 write_en addr 5 data 0x1234, next cycle en addr 5 -> data_out=0x1234; en=0 -> data_out=0x0000, rd_valid=0.
REQ-035 Updates addr 9 delta +3 on three consecutive cycles from 0 -> mem[9]=9, no upd_sat; same-cycle read of 9 returns pre-edge value.
REQ-036 write 0x7FF0 to addr 2, update delta +0x0020 -> mem[2]=0x7FFF, upd_sat pulse; write 0x8005, delta -0x0010 -> 0x8000, upd_sat pulse.
REQ-037 write_en addr 7 data 0x0100 same edge as upd_en addr 7 delta 1 -> mem[7]=0x0101; write addr 7 0x0050 colliding with stage-2 commit to 7 -> mem[7]=0x0050.
REQ-038 Assert rst 10 cycles into sweep, and again with update in stage 1 -> outputs zero immediately, full 64-cycle sweep reruns, pending update never lands.
